// File: rtl/register_file_sb.sv
// Register file with two async read ports, one sync write port and a per-register pending-write scoreboard.
// Latency: reads are combinational (0 cycles); writes/issues commit on the rising edge and show on the next cycle.
// Backpressure: none, every write and issue is accepted each cycle; optional REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic [ADDR_W:0]   BusyCount,
  output logic              AnyBusy
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_count;

  // Writes and issues aimed at a hardwired zero register are dropped here once.
  logic wr_en;
  logic is_en;
  assign wr_en = RegWrite   && !((ZERO_REG != 0) && (WriteAddr == '0));
  assign is_en = IssueValid && !((ZERO_REG != 0) && (IssueAddr == '0));

  // A bit only rises when it was clear, and only falls when a write clears it
  // without a same-address issue re-arming it in the same cycle.
  logic busy_set;
  logic busy_clr;
  assign busy_set = is_en && !busy[IssueAddr];
  assign busy_clr = wr_en && busy[WriteAddr] && !(is_en && (IssueAddr == WriteAddr));

  // Next busy vector: writeback clears first, then a new issue wins on collision.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[WriteAddr] = 1'b0;
    if (is_en) busy_nxt[IssueAddr] = 1'b1;
  end

  // Data storage: synchronous reset clears every register and overrides writes.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[WriteAddr] <= WriteData;
    end
  end

  // Scoreboard bits.
  always_ff @(posedge Clock) begin
    if (!Reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Busy population counter tracks the net change of the scoreboard per edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      busy_count <= '0;
    end else if (busy_set && !busy_clr) begin
      busy_count <= busy_count + {{ADDR_W{1'b0}}, 1'b1};
    end else if (busy_clr && !busy_set) begin
      busy_count <= busy_count - {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  assign BusyCount = busy_count;
  assign AnyBusy   = (busy_count != '0);

  // Read port 1: stored value, optionally forwarded from the write port, zero register forced last.
  always_comb begin
    ReadData1 = regs[ReadAddr1];
    ReadBusy1 = busy[ReadAddr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (WriteAddr == ReadAddr1)) begin
      ReadData1 = WriteData;
      ReadBusy1 = is_en && (IssueAddr == ReadAddr1);
    end
`endif
    if ((ZERO_REG != 0) && (ReadAddr1 == '0)) begin
      ReadData1 = '0;
      ReadBusy1 = 1'b0;
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    ReadData2 = regs[ReadAddr2];
    ReadBusy2 = busy[ReadAddr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (WriteAddr == ReadAddr2)) begin
      ReadData2 = WriteData;
      ReadBusy2 = is_en && (IssueAddr == ReadAddr2);
    end
`endif
    if ((ZERO_REG != 0) && (ReadAddr2 == '0)) begin
      ReadData2 = '0;
      ReadBusy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two instances (ZERO_REG=1 and ZERO_REG=0) driven by shared inputs.
// Each step checks combinational outputs mid-cycle against an array-based reference model.
// Directed scenarios first, then a randomized run, then a summary line.
module tb_register_file_sb;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr, IssueAddr;
  logic [31:0] WriteData;
  logic        RegWrite, IssueValid;

  logic [1:0][31:0] rd1, rd2;
  logic [1:0]       rb1, rb2, anyb;
  logic [1:0][5:0]  bcnt;

  always #5 Clock = ~Clock;

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut_z (
    .Clock(Clock), .Reset(Reset),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]),
    .ReadBusy1(rb1[0]), .ReadBusy2(rb2[0]),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr),
    .BusyCount(bcnt[0]), .AnyBusy(anyb[0])
  );

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_n (
    .Clock(Clock), .Reset(Reset),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]),
    .ReadBusy1(rb1[1]), .ReadBusy2(rb2[1]),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr),
    .BusyCount(bcnt[1]), .AnyBusy(anyb[1])
  );

  // Reference state: index 0 models the hardwired-zero build, index 1 the plain build.
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit is_zr(input int z);
    return (z == 0);
  endfunction

  function automatic int popc(input int z);
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_busy[z][i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] exp_data(input int z, input logic [4:0] a);
    if (is_zr(z) && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteAddr == a) return WriteData;
`endif
    return m_regs[z][a];
  endfunction

  function automatic logic exp_busy(input int z, input logic [4:0] a);
    if (is_zr(z) && a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteAddr == a) return IssueValid && (IssueAddr == a);
`endif
    return m_busy[z][a];
  endfunction

  task automatic cmp(input string tag, input int z, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s inst%0d: observed %h expected %h", tag, z, got, exp);
    end
  endtask

  task automatic check_all();
    for (int z = 0; z < 2; z++) begin
      cmp("ReadData1", z, rd1[z], exp_data(z, ReadAddr1));
      cmp("ReadData2", z, rd2[z], exp_data(z, ReadAddr2));
      cmp("ReadBusy1", z, 32'(rb1[z]), 32'(exp_busy(z, ReadAddr1)));
      cmp("ReadBusy2", z, 32'(rb2[z]), 32'(exp_busy(z, ReadAddr2)));
      cmp("BusyCount", z, 32'(bcnt[z]), popc(z));
      cmp("AnyBusy",   z, 32'(anyb[z]), 32'(popc(z) != 0));
    end
  endtask

  // Commit the edge's effects to the model: reset wins, write clears busy, issue sets it last.
  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      if (!Reset) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[z][i] = 32'h0;
          m_busy[z][i] = 1'b0;
        end
      end else begin
        if (RegWrite && !(is_zr(z) && WriteAddr == 5'd0)) begin
          m_regs[z][WriteAddr] = WriteData;
          m_busy[z][WriteAddr] = 1'b0;
        end
        if (IssueValid && !(is_zr(z) && IssueAddr == 5'd0))
          m_busy[z][IssueAddr] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ia, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge Clock);
    Reset = rst; RegWrite = we; WriteAddr = wa; WriteData = wd;
    IssueValid = iv; IssueAddr = ia; ReadAddr1 = ra1; ReadAddr2 = ra2;
    #1;
    check_all();
    @(posedge Clock);
    model_edge();
  endtask

  initial begin
    Reset = 1'b0; RegWrite = 1'b0; WriteAddr = '0; WriteData = '0;
    IssueValid = 1'b0; IssueAddr = '0; ReadAddr1 = '0; ReadAddr2 = '0;
    repeat (2) @(posedge Clock);
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < 32; i++) begin
        m_regs[z][i] = 32'h0;
        m_busy[z][i] = 1'b0;
      end

    // Reset clears a freshly written register.
    drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd5);
    drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
    drive(1, 0, 0, 0, 0, 0, 5'd5, 5'd0);

    // Zero register handling.
    drive(1, 1, 5'd0, 32'h12345678, 0, 0, 5'd0, 5'd7);
    drive(1, 1, 5'd7, 32'h12345678, 0, 0, 5'd0, 5'd7);
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd7);

    // Issue r3, r4, r3 then write back r3.
    drive(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd4);
    drive(1, 0, 0, 0, 1, 5'd4, 5'd3, 5'd4);
    drive(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd4);
    drive(1, 1, 5'd3, 32'h55, 0, 0, 5'd3, 5'd4);
    drive(1, 0, 0, 0, 0, 0, 5'd3, 5'd4);

    // Same-edge write and issue to r9; issue to r0 on the plain build.
    drive(1, 1, 5'd9, 32'hAA, 1, 5'd9, 5'd9, 5'd0);
    drive(1, 0, 0, 0, 1, 5'd0, 5'd9, 5'd0);
    drive(1, 0, 0, 0, 0, 0, 5'd9, 5'd0);

    // Write r12 while reading it on port 2 (forwarding visible only in bypass builds).
    drive(1, 1, 5'd12, 32'hCAFE, 0, 0, 5'd1, 5'd12);
    drive(1, 0, 0, 0, 0, 0, 5'd1, 5'd12);

    // Reset with busy registers outstanding and a write presented.
    drive(1, 0, 0, 0, 1, 5'd20, 5'd20, 5'd4);
    drive(0, 1, 5'd21, 32'h77, 1, 5'd22, 5'd21, 5'd4);
    drive(1, 0, 0, 0, 0, 0, 5'd21, 5'd22);

    // Fill the whole scoreboard, then drain it with writebacks.
    for (int i = 0; i < 32; i++) drive(1, 0, 0, 0, 1, 5'(i), 5'(i), 5'(31 - i));
    drive(1, 0, 0, 0, 1, 5'd17, 5'd17, 5'd0);
    for (int i = 0; i < 32; i++) drive(1, 1, 5'(i), 32'(i * 3 + 1), 0, 0, 5'(i), 5'(i ^ 1));

    // Randomized traffic with occasional resets and frequent register-0 targets.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, ia, a1, a2;
      wa = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ia = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 1)), ia, a1, a2);
    end
    drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd31);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
